// File: rtl/mapu_pkg.sv
// Shared matrix geometry and element-index helpers for the MAPU output serializer.
package mapu_pkg;

    localparam int MAPU_ROWS  = 3;
    localparam int MAPU_COLS  = 3;
    localparam int MAPU_ELEMS = MAPU_ROWS * MAPU_COLS;

    typedef logic [3:0] mapu_el_idx_t;

    localparam mapu_el_idx_t MAPU_LAST_IDX = mapu_el_idx_t'(MAPU_ELEMS - 1);

    // Row-major walk through one matrix, wrapping after the last element.
    function automatic mapu_el_idx_t mapu_next_idx(input mapu_el_idx_t idx);
        return (idx == MAPU_LAST_IDX) ? '0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/mapu_out_serializer_if.sv
// Matrix intake and element stream bundle between the MAPU, the serializer and its consumer.
interface mapu_out_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    import mapu_pkg::*;

    // Both channels are valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; a raised valid and its payload stay put until that transfer.
    logic                      i_mat_vld;
    logic [3*DATA_WIDTH-1:0]   i_mat_r0;
    logic [3*DATA_WIDTH-1:0]   i_mat_r1;
    logic [3*DATA_WIDTH-1:0]   i_mat_r2;
    logic                      o_mat_rdy;

    logic                      o_el_vld;
    logic [DATA_WIDTH-1:0]     o_el_data;
    mapu_el_idx_t              o_el_idx;
    logic                      o_el_last;
    logic                      i_el_rdy;

    modport master (
        output i_mat_vld, i_mat_r0, i_mat_r1, i_mat_r2, i_el_rdy,
        input  o_mat_rdy, o_el_vld, o_el_data, o_el_idx, o_el_last
    );

    modport slave (
        input  i_mat_vld, i_mat_r0, i_mat_r1, i_mat_r2, i_el_rdy,
        output o_mat_rdy, o_el_vld, o_el_data, o_el_idx, o_el_last
    );

endinterface

// File: rtl/mapu_mat_fifo.sv
// Whole-matrix FIFO: DEPTH entries of nine packed elements, with its own occupancy register.
module mapu_mat_fifo
    import mapu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int OCC_W     = PTR_W + 1,
    localparam int ENTRY_W   = MAPU_ELEMS * DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [OCC_W-1:0]   occ,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ_q;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (occ_q == OCC_W'(DEPTH));
    assign empty   = (occ_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally; occupancy is tracked separately so full/empty never alias.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is not reset: stale contents are never visible because occ gates the output.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
    assign occ  = occ_q;

endmodule

// File: rtl/mapu_out_serializer.sv
// Buffers whole 3x3 MAPU result matrices and streams them out one element per handshake.
// Define MAPU_OUT_SERIALIZER_PERF_EN to add the o_mat_cnt completed-matrix counter.
module mapu_out_serializer
    import mapu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_en,
    mapu_out_serializer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   o_occ
`ifdef MAPU_OUT_SERIALIZER_PERF_EN
    ,
    output logic [31:0]              o_mat_cnt
`endif
);

    localparam int ENTRY_W = MAPU_ELEMS * DATA_WIDTH;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    wdata;
    logic [ENTRY_W-1:0]    head;
    mapu_el_idx_t          idx;
    logic                  el_hs;
    logic                  el_last_hs;
    logic [DATA_WIDTH-1:0] el_mux;

    // Row 0 lands in the low bits, so element k (= row*3+col) sits at slice k.
    assign wdata = {bus.i_mat_r2, bus.i_mat_r1, bus.i_mat_r0};

    // Ready depends only on registered occupancy and enable; reset_n keeps it low in reset.
    assign bus.o_mat_rdy = reset_n && i_en && !full;
    assign push          = bus.i_mat_vld && bus.o_mat_rdy;

    assign bus.o_el_vld  = !empty;
    assign el_hs         = bus.o_el_vld && bus.i_el_rdy;
    assign el_last_hs    = el_hs && (idx == MAPU_LAST_IDX);
    assign pop           = el_last_hs;

    mapu_mat_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (wdata),
        .pop     (pop),
        .head    (head),
        .occ     (o_occ),
        .full    (full),
        .empty   (empty)
    );

    // The index only moves on a handshake, so a stalled element holds data/idx/last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (el_hs) begin
            idx <= mapu_next_idx(idx);
        end
    end

    always_comb begin
        el_mux = '0;
        for (int k = 0; k < MAPU_ELEMS; k++) begin
            if (idx == mapu_el_idx_t'(k)) el_mux = head[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.o_el_data = bus.o_el_vld ? el_mux : '0;
    assign bus.o_el_idx  = idx;
    assign bus.o_el_last = bus.o_el_vld && (idx == MAPU_LAST_IDX);

`ifdef MAPU_OUT_SERIALIZER_PERF_EN
    // Counts finished matrices independent of i_en; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_mat_cnt <= '0;
        end else if (el_last_hs) begin
            o_mat_cnt <= o_mat_cnt + 32'd1;
        end
    end
`endif

endmodule
